// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle for pipelined_csel_adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined conditional-sum adder/subtractor, global-stall
// valid/ready pipeline with carry-in and signed overflow.
module pipelined_csel_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_csel_adder_if.slave bus
);
  localparam int L = $clog2(WIDTH);

  // s0/s1: block sums for carry-in 0/1
  // k0/k1: block carries, indexed by block
  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] k0;
    logic [WIDTH-1:0] k1;
    logic             c0;
    logic             am;
    logic             bm;
  } lvl_t;

  // Register index placed after merge level j, 0 if none.
  function automatic int f_stage_at(input int j);
    int r;
    r = 0;
    for (int k = 1; k < STAGES; k++)
      if ((k * (L + 1)) / STAGES == j) r = k;
    return r;
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  lvl_t             w_leaf;
  lvl_t             w_lvl [L+1];
  lvl_t             w_q   [L+1];
  lvl_t             w_f;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_unused;

  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  assign w_adv        = !r_v[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Leaf: per-bit sum and carry for both assumed carry-ins.
  always_comb begin
    w_bx      = bus.sub ? ~bus.b : bus.b;
    w_leaf.c0 = bus.sub ? ~bus.cin : bus.cin;
    w_leaf.s0 = bus.a ^ w_bx;
    w_leaf.s1 = ~(bus.a ^ w_bx);
    w_leaf.k0 = bus.a & w_bx;
    w_leaf.k1 = bus.a | w_bx;
    w_leaf.am = bus.a[WIDTH-1];
    w_leaf.bm = w_bx[WIDTH-1];
  end

  assign w_lvl[0] = w_leaf;

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    localparam int N  = 1 << j;
    localparam int H  = N / 2;
    localparam int NB = WIDTH / N;
    lvl_t w_p;
    lvl_t w_m;
    assign w_p = w_q[j-1];
    // Merge pairs: upper half picks its pair by lower carries.
    always_comb begin
      w_m = w_p;
      for (int i = 0; i < NB; i++) begin
        w_m.s0[i*N+H +: H] = w_p.k0[2*i] ?
          w_p.s1[i*N+H +: H] : w_p.s0[i*N+H +: H];
        w_m.s1[i*N+H +: H] = w_p.k1[2*i] ?
          w_p.s1[i*N+H +: H] : w_p.s0[i*N+H +: H];
        w_m.k0[i] = w_p.k0[2*i] ?
          w_p.k1[2*i+1] : w_p.k0[2*i+1];
        w_m.k1[i] = w_p.k1[2*i] ?
          w_p.k1[2*i+1] : w_p.k0[2*i+1];
      end
    end
    assign w_lvl[j] = w_m;
  end

  for (genvar j = 0; j <= L; j++) begin : g_bnd
    if (f_stage_at(j) != 0) begin : g_reg
      lvl_t r_q;
      // Intermediate stage register; holds while stalled.
      always_ff @(posedge clk) begin
        if (!rst_n)     r_q <= '0;
        else if (w_adv) r_q <= w_lvl[j];
      end
      assign w_q[j] = r_q;
    end else begin : g_thru
      assign w_q[j] = w_lvl[j];
    end
  end

  assign w_f    = w_q[L];
  assign w_sum  = w_f.c0 ? w_f.s1 : w_f.s0;
  assign w_cout = w_f.c0 ? w_f.k1[0] : w_f.k0[0];
  assign w_ovf  = (w_f.am == w_f.bm) &&
                  (w_sum[WIDTH-1] != w_f.am);

  // Top-level block carries only exist at index 0.
  assign w_unused = ^{w_f.k0[WIDTH-1:1], w_f.k1[WIDTH-1:1]};

  // Valid chain: every stage advances together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++)
        r_v[k] <= r_v[k-1];
    end
  end

  // Output register after the final carry-in select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.out_valid = r_v[STAGES-1];
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
